// File: rtl/seq_shift_unit_pkg.sv
// Shared types for the multi-cycle shift/rotate unit: ALU shift opcodes, FSM states
// and the opcode legality check.
package seq_shift_unit_pkg;

    typedef enum logic [4:0] {
        OP_SHR  = 5'b01000,
        OP_SHRA = 5'b01001,
        OP_SHL  = 5'b01010,
        OP_ROR  = 5'b01011,
        OP_ROL  = 5'b01100
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_shift_op(input logic [4:0] op);
        logic legal;
        case (op)
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/response bundle between the ALU sequencer (master) and the shift unit (slave).
interface seq_shift_unit_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [AMT_W-1:0] amt;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (output start, op, a, amt, input  busy, done, err, result);
    modport slave  (input  start, op, a, amt, output busy, done, err, result);
endinterface

// File: rtl/seq_shift_unit_shift_step.sv
// Combinational single step: shifts/rotates acc by s (0..STEP) positions according to op.
module seq_shift_unit_shift_step
    import seq_shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int SW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [4:0]       op_i,
    input  logic [SW-1:0]    s_i,
    output logic [WIDTH-1:0] acc_o
);

    logic [2*WIDTH-1:0] dbl_s;
    logic [2*WIDTH-1:0] ror_s;
    logic [2*WIDTH-1:0] rol_s;

    // Rotates are taken from a doubled operand so no shift ever reaches WIDTH.
    always_comb begin
        dbl_s = {acc_i, acc_i};
        ror_s = dbl_s >> s_i;
        rol_s = dbl_s << s_i;
        case (op_i)
            OP_SHR:  acc_o = acc_i >> s_i;
            OP_SHRA: acc_o = $unsigned($signed(acc_i) >>> s_i);
            OP_SHL:  acc_o = acc_i << s_i;
            OP_ROR:  acc_o = ror_s[WIDTH-1:0];
            OP_ROL:  acc_o = rol_s[2*WIDTH-1:WIDTH];
            default: acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: shifts at most STEP positions per clock with a
// start/busy/done handshake; result is held until the next completed operation.
module seq_shift_unit
    import seq_shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AMT_W = 5
) (
    input  logic            clk_i,
    input  logic            clear_i,
    seq_shift_unit_if.slave bus
);

    localparam int SW = $clog2(STEP + 1);
    localparam logic [AMT_W:0] STEP_W = (AMT_W + 1)'(STEP);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [AMT_W-1:0]   rem_q, rem_d;
    logic [4:0]         opr_q, opr_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [AMT_W:0]     s_wide_s;
    logic [SW-1:0]      s_s;
    logic [WIDTH-1:0]   step_acc_s;
    logic               legal_s;

    // Step size for the current cycle: min(STEP, remaining count).
    always_comb begin
        if ({1'b0, rem_q} >= STEP_W) begin
            s_wide_s = STEP_W;
        end else begin
            s_wide_s = {1'b0, rem_q};
        end
        s_s = s_wide_s[SW-1:0];
    end

    seq_shift_unit_shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .SW    (SW)
    ) u_step (
        .acc_i (acc_q),
        .op_i  (opr_q),
        .s_i   (s_s),
        .acc_o (step_acc_s)
    );

    assign legal_s = is_shift_op(bus.op);

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opr_d    = opr_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    acc_d = bus.a;
                    rem_d = bus.amt;
                    opr_d = bus.op;
                    // Zero count and illegal ops finish immediately with the operand unchanged.
                    if ((bus.amt == {AMT_W{1'b0}}) || !legal_s) begin
                        state_d  = ST_DONE;
                        result_d = bus.a;
                        done_d   = 1'b1;
                        err_d    = !legal_s;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                acc_d = step_acc_s;
                rem_d = rem_q - s_wide_s[AMT_W-1:0];
                if (rem_d == {AMT_W{1'b0}}) begin
                    state_d  = ST_DONE;
                    result_d = step_acc_s;
                    done_d   = 1'b1;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_BUSY);
    end

    // State and output registers; Clear aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q  <= ST_IDLE;
            acc_q    <= {WIDTH{1'b0}};
            rem_q    <= {AMT_W{1'b0}};
            opr_q    <= 5'b00000;
            result_q <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opr_q    <= opr_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit (WIDTH=32, STEP=4) with hand-computed expectations.
module tb_seq_shift_unit;
    import seq_shift_unit_pkg::*;

    logic clk;
    logic clear;
    int   n_chk;
    int   n_pass;
    int   lat;
    int   bcnt;
    int   dcnt;

    seq_shift_unit_if #(.WIDTH(32), .AMT_W(5)) bus ();

    seq_shift_unit #(.WIDTH(32), .STEP(4), .AMT_W(5)) dut (
        .clk_i   (clk),
        .clear_i (clear),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [4:0] amt);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.amt   = amt;
    endtask

    // Counts negedges until done (cycle index relative to the start cycle), bounded.
    task automatic wait_done(output int l, output int b);
        l = 0;
        b = 0;
        for (int k = 1; k <= 40; k++) begin
            if (l == 0) begin
                @(negedge clk);
                bus.start = 1'b0;
                if (bus.busy) b++;
                if (bus.done) l = k;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [4:0] amt, input logic [31:0] exp_res,
                          input logic exp_err, input int exp_lat);
        @(negedge clk);
        issue(op, a, amt);
        wait_done(lat, bcnt);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy"}, 32'(bcnt), 32'(exp_lat - 1));
        chk({tag, "_res"}, bus.result, exp_res);
        chk({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        clear     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 5'b00000;
        bus.a     = 32'h0;
        bus.amt   = 5'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_result", bus.result, 32'h0);
        clear = 1'b0;

        run_op("shl20",  OP_SHL,  32'h00000012, 5'd20, 32'h01200000, 1'b0, 6);
        run_op("shra4",  OP_SHRA, 32'h80000010, 5'd4,  32'hF8000001, 1'b0, 2);
        run_op("shr4",   OP_SHR,  32'h80000010, 5'd4,  32'h08000001, 1'b0, 2);
        run_op("ror8",   OP_ROR,  32'h00000012, 5'd8,  32'h12000000, 1'b0, 3);
        run_op("rol1",   OP_ROL,  32'h80000001, 5'd1,  32'h00000003, 1'b0, 2);
        run_op("ror31",  OP_ROR,  32'h00000001, 5'd31, 32'h00000002, 1'b0, 9);
        run_op("shra7",  OP_SHRA, 32'h40000000, 5'd7,  32'h00800000, 1'b0, 3);
        run_op("amt0",   OP_SHL,  32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0, 1);
        run_op("illegal", 5'b00011, 32'h00001234, 5'd5, 32'h00001234, 1'b1, 1);

        // start while busy must be dropped, not queued
        @(negedge clk);
        issue(OP_SHL, 32'h00000001, 5'd8);
        @(negedge clk);
        chk("ign_busy_c1", {31'd0, bus.busy}, 32'd1);
        issue(OP_SHR, 32'h0000FFFF, 5'd4);
        wait_done(lat, bcnt);
        chk("ign_lat", 32'(lat), 32'd2);
        chk("ign_res", bus.result, 32'h00000100);
        @(negedge clk);
        chk("ign_no_requeue_busy", {31'd0, bus.busy}, 32'd0);
        chk("ign_no_requeue_done", {31'd0, bus.done}, 32'd0);

        // back-to-back: new start in the DONE cycle
        @(negedge clk);
        issue(OP_SHL, 32'h00000001, 5'd4);
        wait_done(lat, bcnt);
        chk("b2b_first_res", bus.result, 32'h00000010);
        issue(OP_ROL, 32'h80000000, 5'd4);
        wait_done(lat, bcnt);
        chk("b2b_second_lat", 32'(lat), 32'd2);
        chk("b2b_second_res", bus.result, 32'h00000008);

        // Clear during BUSY cycle 2 aborts with no done pulse
        @(negedge clk);
        issue(OP_SHL, 32'h00000012, 5'd20);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_result", bus.result, 32'h0);
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
